// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side handshake bundle of the UART receiver.
//   rx_data     - last correctly framed byte
//   rx_valid    - one-cycle pulse marking rx_data as new
//   rx_busy     - high while a frame is in progress
//   frame_error - one-cycle pulse when the stop bit samples low
// master: the receiver (drives everything); slave: the consumer (e.g. Rx FIFO writer).
interface uart_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_error;
   modport master (output rx_data, rx_valid, rx_busy, frame_error);
   modport slave  (input  rx_data, rx_valid, rx_busy, frame_error);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver with mid-bit sampling and framing-error detection.
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   rx      - asynchronous serial line, idle high
//   bus     - uart_rx_if.master: rx_data, rx_valid, rx_busy, frame_error
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic      clock,
   input  logic      reset_n,
   input  logic      rx,
   uart_rx_if.master bus
);
   localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF = 16'(HALF_BIT);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
   state_t      state;
   logic [1:0]  sync;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic        rx_sync;
   assign rx_sync     = sync[1];
   assign bus.rx_busy = state != IDLE;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         sync            <= 2'b11;
         state           <= IDLE;
         cnt             <= '0;
         idx             <= '0;
         shreg           <= '0;
         bus.rx_data     <= '0;
         bus.rx_valid    <= 1'b0;
         bus.frame_error <= 1'b0;
      end else begin
         sync            <= {sync[0], rx};
         bus.rx_valid    <= 1'b0;
         bus.frame_error <= 1'b0;
         case (state)
            IDLE: if (!rx_sync) begin
               state <= START;
               cnt   <= '0;
            end
            // Re-check the line at mid start bit so short glitches are rejected.
            START: if (cnt == HALF) begin
               state <= rx_sync ? IDLE : DATA;
               cnt   <= '0;
               idx   <= '0;
            end else cnt <= cnt + 16'd1;
            DATA: if (cnt == LAST) begin
               shreg <= {rx_sync, shreg[7:1]};
               cnt   <= '0;
               idx   <= idx + 3'd1;
               if (idx == 3'd7) state <= STOP;
            end else cnt <= cnt + 16'd1;
            STOP: if (cnt == LAST) begin
               cnt <= '0;
               if (rx_sync) begin
                  bus.rx_data  <= shreg;
                  bus.rx_valid <= 1'b1;
                  state        <= IDLE;
               end else begin
                  bus.frame_error <= 1'b1;
                  state           <= WAIT_IDLE;
               end
            end else cnt <= cnt + 16'd1;
            // A stuck-low line reports one error, then waits for it to recover.
            WAIT_IDLE: if (rx_sync) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a queue-based frame model.
module tb_uart_rx;
   localparam int CPB = 16;
   localparam int LAT = 155;
   typedef struct {
      logic       ferr;
      logic [7:0] d;
      int         t0;
   } exp_t;
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic rx = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   n_valid = 0;
   int   n_ferr = 0;
   logic [7:0] last_good = '0;
   logic prev_pulse = 1'b0;
   logic prev_busy = 1'b0;
   exp_t q[$];
   int   vt[$];
   uart_rx_if bus ();
   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .rx      (rx),
      .bus     (bus.master)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask
   always @(negedge clock) begin
      if (reset_n && (bus.rx_valid || bus.frame_error)) begin
         exp_t e;
         chk("exclusive", 32'(bus.rx_valid & bus.frame_error), 0);
         chk("one_cycle", 32'(prev_pulse), 0);
         chk("busy_edge", {30'd0, prev_busy, bus.rx_busy}, {30'd0, 1'b1, bus.frame_error});
         if (q.size() == 0) chk("unexpected_pulse", 1, 0);
         else begin
            e = q.pop_front();
            chk("kind", 32'(bus.frame_error), 32'(e.ferr));
            chk("latency", 32'(cyc - e.t0), LAT);
            if (bus.rx_valid) begin
               chk("data", 32'(bus.rx_data), 32'(e.d));
               last_good = e.d;
            end else chk("data_hold", 32'(bus.rx_data), 32'(last_good));
         end
         if (bus.rx_valid) begin
            n_valid++;
            vt.push_back(cyc);
         end else n_ferr++;
      end
      prev_pulse = bus.rx_valid | bus.frame_error;
      prev_busy  = bus.rx_busy;
   end
   task automatic align();
      @(posedge clock);
      #1;
   endtask
   task automatic wait_to(input int t);
      while (cyc < t) @(negedge clock);
   endtask
   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) @(posedge clock);
      #1;
   endtask
   task automatic send_frame(input logic [7:0] d, input logic stop, input int gap_bits);
      q.push_back('{ferr: !stop, d: d, t0: cyc});
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
      repeat (gap_bits) drive_bit(1'b1);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int c, nv, nf;
      repeat (3) @(negedge clock);
      chk("rst_data", 32'(bus.rx_data), 0);
      chk("rst_flags", {29'd0, bus.rx_valid, bus.frame_error, bus.rx_busy}, 0);
      reset_n = 1'b1;
      repeat (4) align();
      send_frame(8'hA5, 1'b1, 2);
      chk("a5_count", 32'(n_valid), 1);
      nv = n_valid; nf = n_ferr;
      c = cyc;
      rx = 1'b0;
      repeat (4) @(posedge clock);
      #1 rx = 1'b1;
      wait_to(c + 10);
      chk("glitch_busy", 32'(bus.rx_busy), 1);
      wait_to(c + 11);
      chk("glitch_idle", 32'(bus.rx_busy), 0);
      repeat (20) @(negedge clock);
      chk("glitch_pulses", 32'(n_valid + n_ferr), 32'(nv + nf));
      chk("glitch_data", 32'(bus.rx_data), 32'hA5);
      align();
      nv = n_valid; nf = n_ferr;
      send_frame(8'h00, 1'b0, 0);
      repeat (40 * CPB) @(posedge clock);
      #1;
      c = cyc;
      rx = 1'b1;
      wait_to(c + 2);
      chk("break_busy", 32'(bus.rx_busy), 1);
      wait_to(c + 3);
      chk("break_idle", 32'(bus.rx_busy), 0);
      chk("break_ferr", 32'(n_ferr - nf), 1);
      chk("break_valid", 32'(n_valid - nv), 0);
      chk("break_data", 32'(bus.rx_data), 32'hA5);
      align();
      drive_bit(1'b1);
      vt.delete();
      send_frame(8'h55, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 2);
      chk("b2b_count", 32'(vt.size()), 2);
      if (vt.size() == 2) chk("b2b_gap", 32'(vt[1] - vt[0]), 160);
      rx = 1'b0;
      repeat (CPB) @(posedge clock);
      for (int i = 0; i < 3; i++) repeat (CPB) @(posedge clock);
      rx = 1'b1;
      repeat (CPB / 2) @(posedge clock);
      #1 reset_n = 1'b0;
      rx = 1'b1;
      @(negedge clock);
      chk("mid_rst_data", 32'(bus.rx_data), 0);
      chk("mid_rst_flags", {29'd0, bus.rx_valid, bus.frame_error, bus.rx_busy}, 0);
      last_good = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      align();
      drive_bit(1'b1);
      nv = n_valid;
      send_frame(8'h81, 1'b1, 2);
      chk("post_rst_count", 32'(n_valid - nv), 1);
      chk("post_rst_data", 32'(bus.rx_data), 32'h81);
      send_frame(8'h12, 1'b1, 1);
      nv = n_valid;
      for (int i = 0; i < 10; i++) begin
         repeat (100) @(negedge clock);
         chk("hold_data", 32'(bus.rx_data), 32'h12);
      end
      chk("hold_valid", 32'(n_valid - nv), 0);
      align();
      for (int i = 0; i < 30; i++) begin
         logic [7:0] d;
         logic s;
         d = 8'($urandom);
         s = $urandom_range(0, 4) != 0;
         send_frame(d, s, s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
      end
      repeat (3 * CPB) @(negedge clock);
      chk("drain", 32'(q.size()), 0);
      chk("final_busy", 32'(bus.rx_busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
